// File: rtl/fetch_stage.sv
// Purpose: MIPS instruction-fetch stage; owns the PC and the instruction-memory request handshake.
// Latency: 1 + W cycles in FETCH (W = memory wait cycles), then at least one cycle in HAVE.
// Backpressure: StallF freezes the PC and held instruction in HAVE; an outstanding fetch cannot be cancelled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        StallF,
    input  logic        pc_src_D,
    input  logic [31:0] pc_branch_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus_four_F,
    output logic [31:0] instruction_F,
    output logic        fetch_valid_F,
    output logic        fetch_busy_F
);

    typedef enum logic {
        FETCH = 1'b0,
        HAVE  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        redirect_pending_q, redirect_pending_d;
    logic [31:0] redirect_target_q, redirect_target_d;

    // Next-state logic: complete or redirect an outstanding fetch, or advance out of HAVE.
    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        inst_buf_d         = inst_buf_q;
        redirect_pending_d = redirect_pending_q;
        redirect_target_d  = redirect_target_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect_pending_q || pc_src_D) begin
                        // The returning word belongs to the wrong path: drop it and
                        // refetch from the redirect, a same-cycle branch taking priority.
                        pc_d               = pc_src_D ? pc_branch_D : redirect_target_q;
                        redirect_pending_d = 1'b0;
                    end else begin
                        inst_buf_d = imem_rdata;
                        state_d    = HAVE;
                    end
                end else if (pc_src_D) begin
                    // Remember the branch until the in-flight request drains; last one wins.
                    redirect_pending_d = 1'b1;
                    redirect_target_d  = pc_branch_D;
                end
            end
            HAVE: begin
                // While stalled, decode re-presents any branch later, so pc_src_D is ignored here.
                if (!StallF) begin
                    pc_d    = pc_src_D ? pc_branch_D : pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State register with synchronous active-low reset; reset abandons any in-flight request.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q            <= FETCH;
            pc_q               <= RESET_PC;
            inst_buf_q         <= 32'd0;
            redirect_pending_q <= 1'b0;
            redirect_target_q  <= 32'd0;
        end else begin
            state_q            <= state_d;
            pc_q               <= pc_d;
            inst_buf_q         <= inst_buf_d;
            redirect_pending_q <= redirect_pending_d;
            redirect_target_q  <= redirect_target_d;
        end
    end

    assign imem_req       = reset_n & (state_q == FETCH);
    assign imem_addr      = pc_q;
    assign pc_plus_four_F = pc_q + 32'd4;
    assign instruction_F  = (state_q == HAVE) ? inst_buf_q : NOP_INSTR;
    assign fetch_valid_F  = (state_q == HAVE);
    assign fetch_busy_F   = (state_q == FETCH);

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; owns the PC register and the instruction-memory request handshake.
- Produces pc_plus_four_F, instruction_F and fetch_valid_F, which feed the F→D pipeline register.
- Consumes StallF from the hazard unit, plus the branch redirect (pc_src_D, pc_branch_D) resolved in decode.
- Handles variable-latency instruction memory and keeps a branch redirect that arrives while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction presented while no valid instruction is held.

Ports:
- clock  input  1  pipeline clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- StallF  input  1  hazard-unit stall; the PC and the held instruction must not advance.
- pc_src_D  input  1  branch taken in decode (one-cycle pulse).
- pc_branch_D  input  32  branch target from decode.
- imem_req  output  1  instruction-memory request valid.
- imem_addr  output  32  request address (current PC).
- imem_ready  input  1  memory response valid; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- pc_plus_four_F  output  32  PC+4 of the current PC.
- instruction_F  output  32  held instruction, or NOP_INSTR.
- fetch_valid_F  output  1  instruction_F is a real instruction.
- fetch_busy_F  output  1  fetch outstanding (state FETCH); a status signal for the hazard unit.

Behaviour:
- State: pc[31:0], inst_buf[31:0], redirect_pending, redirect_target[31:0], FSM {FETCH, HAVE}.
- Reset (reset_n=0 at edge):
  - pc←RESET_PC, state←FETCH, inst_buf←0, redirect_pending←0, redirect_target←0.
  - While reset_n=0: imem_req=0 and imem_ready is ignored.
  - A reset mid-request abandons that request; imem shares reset_n and drops it too.
- Combinational outputs:
  - imem_addr=pc.
  - imem_req = reset_n & (state==FETCH).
  - pc_plus_four_F = pc+32'd4, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000).
  - instruction_F = (state==HAVE) ? inst_buf : NOP_INSTR.
  - fetch_valid_F = (state==HAVE).
  - fetch_busy_F = (state==FETCH).
- FETCH:
  - imem_req is held high and imem_addr is held stable until an edge with imem_ready=1.
  - imem_ready=1, no redirect pending and pc_src_D=0: inst_buf←imem_rdata, state←HAVE.
  - imem_ready=1 and (redirect_pending=1 or pc_src_D=1):
    - discard imem_rdata;
    - pc←(pc_src_D ? pc_branch_D : redirect_target);
    - redirect_pending←0; stay in FETCH.
    - The new request is issued in the next cycle.
  - imem_ready=0 and pc_src_D=1: redirect_pending←1, redirect_target←pc_branch_D.
    - A later pc_src_D overwrites the target (last one wins).
  - StallF has no effect in FETCH: the outstanding request cannot be cancelled, and a bubble is presented.
- HAVE:
  - StallF=1: hold pc, inst_buf and state. pc_src_D is ignored, because the hazard unit keeps decode stalled and re-presents it.
  - StallF=0 and pc_src_D=0: pc←pc+4, state←FETCH.
  - StallF=0 and pc_src_D=1: pc←pc_branch_D, state←FETCH. The instruction shown this cycle is flushed by the decode register clear; this block does nothing extra.
- Latency:
  - Fetch takes 1 + W cycles in FETCH, where W is the number of memory wait cycles (W≥0; with imem_ready tied to 1, FETCH lasts one cycle).
  - Then at least one cycle in HAVE.
  - Peak throughput is one instruction per 2 cycles.
- imem_ready while imem_req=0 is ignored.
- pc is never modified except as listed above.

Test Plan:
- Reset, then release with imem_ready=0 → imem_req=1, imem_addr=0x0, pc_plus_four_F=0x4, instruction_F=0x0, fetch_valid_F=0, fetch_busy_F=1.
- imem_ready tied 1, rdata=0x20080005 at 0x0 and 0x20090007 at 0x4, StallF=0:
  - HAVE at cycle 1 with instruction_F=0x20080005;
  - FETCH at 0x4 at cycle 2;
  - HAVE at cycle 3 with instruction_F=0x20090007.
- 3 wait cycles (imem_ready low for 3 cycles, then high):
  - imem_req stays 1 and imem_addr stays 0x0 for 4 cycles;
  - fetch_valid_F=0 throughout;
  - HAVE on the following cycle.
- In HAVE, StallF=1 for 5 cycles → pc, instruction_F and fetch_valid_F are unchanged and imem_req=0; on StallF=0, pc advances by 4.
- Redirect during a pending fetch:
  - In FETCH at 0x8 with imem_ready=0, pulse pc_src_D with pc_branch_D=0x40.
  - Two cycles later imem_ready=1 with rdata=0xDEADBEEF → the word is discarded and fetch_valid_F stays 0.
  - Next cycle imem_addr=0x40.
- Redirect in HAVE (StallF=0, pc_src_D=1, pc_branch_D=0x100) → next cycle pc=0x100, imem_addr=0x100. Also set pc=0xFFFFFFFC: pc_plus_four_F=0x0, and the next sequential fetch address is 0x0.
